// File: rtl/wb_serial_master.sv
// Wishbone master driven by a serial byte stream: decodes read/write frames,
// runs a single bus transfer with an ack timeout, then returns status/data bytes.
module wb_serial_master #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    output logic        busy
);

    localparam logic [7:0]  CMD_WR  = 8'h01;
    localparam logic [7:0]  CMD_RD  = 8'h02;
    localparam logic [7:0]  RSP_ACK = 8'h06;
    localparam logic [7:0]  RSP_NAK = 8'h15;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_RESP
    } state_t;

    state_t      state_q;
    logic [1:0]  cnt_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic        we_q;
    logic        cyc_q;
    logic        ok_q;
    logic [15:0] to_cnt_q;
    logic [2:0]  idx_q;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q;
    logic        busy_q;
    logic [2:0]  last_idx_d;

    // Byte idx of the response: 0 is the status code, 1..4 the read data MSB first.
    function automatic logic [7:0] resp_byte(input logic [2:0] idx, input logic ok,
                                             input logic [31:0] d);
        logic [7:0] b;
        b = RSP_NAK;
        if (ok) begin
            case (idx)
                3'd1:    b = d[31:24];
                3'd2:    b = d[23:16];
                3'd3:    b = d[15:8];
                3'd4:    b = d[7:0];
                default: b = RSP_ACK;
            endcase
        end
        return b;
    endfunction

    assign last_idx_d = (ok_q && !we_q) ? 3'd4 : 3'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 2'd0;
            adr_q      <= 32'h0;
            dat_q      <= 32'h0;
            we_q       <= 1'b0;
            cyc_q      <= 1'b0;
            ok_q       <= 1'b0;
            to_cnt_q   <= 16'h0;
            idx_q      <= 3'd0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rx_valid && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
                        we_q    <= (rx_data == CMD_WR);
                        cnt_q   <= 2'd0;
                        busy_q  <= 1'b1;
                        state_q <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (rx_valid) begin
                        adr_q <= {adr_q[23:0], rx_data};
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            if (we_q) begin
                                cnt_q   <= 2'd0;
                                state_q <= S_DATA;
                            end else begin
                                cyc_q    <= 1'b1;
                                to_cnt_q <= 16'h0;
                                state_q  <= S_BUS;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        dat_q <= {dat_q[23:0], rx_data};
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            cyc_q    <= 1'b1;
                            to_cnt_q <= 16'h0;
                            state_q  <= S_BUS;
                        end
                    end
                end
                S_BUS: begin
                    // Ack is tested first so it wins over a simultaneous expiry.
                    if (wb_ack_i) begin
                        cyc_q   <= 1'b0;
                        ok_q    <= 1'b1;
                        idx_q   <= 3'd0;
                        state_q <= S_RESP;
                        if (!we_q) dat_q <= wb_dat_i;
                    end else if (to_cnt_q == TO_LAST) begin
                        cyc_q   <= 1'b0;
                        ok_q    <= 1'b0;
                        idx_q   <= 3'd0;
                        state_q <= S_RESP;
                    end else begin
                        to_cnt_q <= to_cnt_q + 16'd1;
                    end
                end
                S_RESP: begin
                    if (!tx_valid_q) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= resp_byte(3'd0, ok_q, dat_q);
                    end else if (tx_ready) begin
                        if (idx_q == last_idx_d) begin
                            tx_valid_q <= 1'b0;
                            busy_q     <= 1'b0;
                            state_q    <= S_IDLE;
                        end else begin
                            idx_q     <= idx_q + 3'd1;
                            tx_data_q <= resp_byte(idx_q + 3'd1, ok_q, dat_q);
                        end
                    end
                end
                default: begin
                    cyc_q      <= 1'b0;
                    tx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_sel_o = 4'hF;
    assign wb_we_o  = we_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;

endmodule

// File: doc/wb_serial_master.md
# wb_serial_master

Wishbone bus master driven by a byte stream. It lets a host on a serial link read and write any slave on the shared bus (boot RAM, UARTs, GPIO, SPI, timer) without the CPU. It sits between a UART's byte-level receive/transmit strobes and a spare master port of the Wishbone interconnect. It is the initiator counterpart of the existing slave peripherals and is used for serial boot loading and debug.

## Interface
Parameters:
- TIMEOUT, 1024: bus cycles to wait for `wb_ack_i` before aborting; legal range 2..65535.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte; valid only while `rx_valid`=1.
- rx_valid  in  1  one-cycle strobe: `rx_data` holds a new byte.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  `tx_data` is valid; held until accepted.
- tx_ready  in  1  transmitter accepts the byte when `tx_valid` & `tx_ready`.
- wb_adr_o  out  32  bus address.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_sel_o  out  4  byte select; constant 4'hF.
- wb_we_o  out  1  write enable.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  strobe; always equal to `wb_cyc_o`.
- wb_ack_i  in  1  slave acknowledge.
- busy  out  1  high in every state except IDLE.

## Operation
- Frame format. Command byte, then 4 address bytes (MSB first). A write adds 4 data bytes (MSB first).
  - 0x01 = write; 0x02 = read.
  - Any other command byte in IDLE is discarded and the block stays in IDLE.
- States:
  - IDLE: wait for a command byte.
  - ADDR: collect 4 address bytes.
  - DATA: collect 4 data bytes (write only).
  - BUS: run the Wishbone cycle.
  - RESP: send the response bytes.
- Transitions:
  - IDLE→ADDR on a valid command.
  - ADDR→DATA after the 4th address byte for a write; ADDR→BUS for a read.
  - DATA→BUS after the 4th data byte.
  - BUS→RESP on ack or on timeout.
  - RESP→IDLE after the last response byte is accepted.
- Byte counter: 2 bits. It increments on each accepted `rx_valid`, wraps 3→0 on a phase change, and resets to 0 on entering ADDR and DATA.
- Address and data shift registers shift left by 8 and load `rx_data` into bits [7:0]. `wb_adr_o` and `wb_dat_o` are driven directly from these registers.
- A read captures `wb_dat_i` into the data register in the cycle `wb_ack_i` is sampled high.
- Responses:
  - Write with ack: 0x06.
  - Read with ack: 0x06, then the 4 read-data bytes MSB first.
  - Timeout: 0x15 only.
- `rx_valid` pulses in BUS or RESP are dropped. There is no inter-byte timeout in ADDR or DATA.
- Reset at any time: on the next clock edge all state returns to IDLE and any in-flight bus cycle is abandoned (`wb_cyc_o` falls).

## Timing
- Reset values:
  - `wb_cyc_o`, `wb_stb_o`, `wb_we_o`, `tx_valid`, `busy`: 0.
  - `wb_adr_o`, `wb_dat_o`: 0.
  - `tx_data`: 8'h00.
  - `wb_sel_o`: 4'hF.
- `wb_cyc_o`/`wb_stb_o` rise in the cycle after the clock edge that samples the final frame byte.
- `wb_we_o`, `wb_adr_o` and `wb_dat_o` are stable for the whole cycle.
- Bus cycle end:
  - `wb_cyc_o`/`wb_stb_o` fall in the cycle after `wb_ack_i` is sampled high.
  - Single transfer only; no bursts (no CTI/BTE).
- Timeout counter:
  - Clears on entry to BUS and increments each cycle that `wb_stb_o`=1 and `wb_ack_i`=0.
  - When the count reaches TIMEOUT-1 with no ack, cyc/stb drop on the next edge and RESP sends 0x15.
  - If ack and expiry occur in the same cycle, ack wins.
- `tx_valid` rises in the cycle after cyc falls, with the first response byte.
- Each response byte stays stable until `tx_valid` & `tx_ready`. The next byte, or `tx_valid`=0, appears in the following cycle, so there is no bubble when `tx_ready` is held high.
- `busy` falls in the cycle after the last response byte is accepted.
- Minimum latency with zero-wait ack and `tx_ready`=1: last rx byte → cyc high, 1 cycle; ack → `tx_valid`, 2 cycles.

## Test plan
- Write: bytes 01 40 00 00 00 DE AD BE EF with a zero-wait-state slave.
  - One cycle with adr=0x40000000, dat=0xDEADBEEF, we=1, sel=F.
  - Then tx 0x06 and `busy` falls.
- Read: bytes 02 00 00 00 10; slave acks after 3 wait states with 0x12345678.
  - One cycle with we=0.
  - Then tx 06 12 34 56 78 in order.
- Timeout: TIMEOUT=8, read with `wb_ack_i` held low.
  - cyc high for exactly 8 cycles, then tx 0x15 only.
  - A following valid frame is still accepted.
- Backpressure and drop: toggle `tx_ready` randomly during a read response, and inject `rx_valid` bytes during BUS/RESP.
  - Each response byte holds until accepted; all 5 bytes arrive.
  - Injected bytes have no effect.
- Bad command and reset: send 0x7F, then 01 plus 2 address bytes, then pulse `reset`.
  - No bus activity occurs.
  - After reset, a full write frame executes correctly.
  - Reset asserted mid-BUS drops cyc on the next edge.
